// File: rtl/fir_pkg.sv
// Shared FIR constants, sample typedefs and a reference requantisation helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

    localparam int FIR_TAPS        = 8;
    localparam int FIR_DATA_WIDTH  = 16;
    localparam int FIR_COEFF_WIDTH = 16;
    localparam int FIR_OUT_WIDTH   = 16;
    localparam int FIR_LATENCY     = 5;
    localparam int FIR_SUM_WIDTH   = FIR_DATA_WIDTH + FIR_COEFF_WIDTH + $clog2(FIR_TAPS);

    typedef logic signed [FIR_SUM_WIDTH-1:0] fir_sum_t;
    typedef logic signed [FIR_OUT_WIDTH-1:0] fir_sample_t;

    // Round half toward +inf, arithmetic shift right, then clamp to a signed
    // out_width range. Works on 64-bit values so any sum width up to 63 fits.
    function automatic logic signed [63:0] round_shift_sat(
        input logic signed [63:0] value,
        input int                 shift,
        input int                 out_width
    );
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_width - 1));
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and a synchronous clear.
// Latency: write visible at the head one cycle later (no bypass).
// Backpressure: push while full is dropped (push_drop) unless a pop frees a slot the same cycle.
// Ports: clr empties the FIFO; push/push_dat write; pop consumes the head;
// pop_vld/pop_dat present the head (pop_dat is 0 when empty); level is occupancy.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic                       pop_vld,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       push_drop,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             empty, full, do_pop, do_push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same slot index, opposite lap bit: writer is a full lap ahead.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    assign do_pop    = pop && !empty && !clr;
    assign do_push   = push && (!full || do_pop) && !clr;
    assign push_drop = push && full && !do_pop && !clr;

    assign pop_vld = !empty;
    assign pop_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_dat;
                wr_ptr_d                = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fir_output_requant.sv
// Requantises the full-precision FIR sum: warm-up discard, round/shift, saturate, decimate, buffer.
// Latency: 2 cycles from in_data to out_data with the FIFO empty.
// Backpressure: out_valid/out_ready on the FIFO head; kept samples arriving while full are dropped and flagged.
// Ports: in_valid/in_data FIR sum in; decim_m decimation factor; flush restarts the
// pipeline; clr_flags clears sticky flags; out_valid/out_ready/out_data result stream;
// sat_flag/ovf_flag sticky status; fifo_level current occupancy.
module fir_output_requant
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = 35,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int WARMUP     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [IN_WIDTH-1:0]    in_data,
    input  logic        [3:0]             decim_m,
    input  logic                          flush,
    input  logic                          clr_flags,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          sat_flag,
    output logic                          ovf_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int RW  = IN_WIDTH + 1;
    localparam int WCW = $clog2(WARMUP + 1);

    localparam logic        [RW-1:0] ROUND_K = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [WCW-1:0]       warm_cnt_q, warm_cnt_d;
    logic                 s1_valid_q, s1_valid_d;
    logic signed [RW-1:0] s1_r_q, s1_r_d;
    logic [3:0]           phase_q, phase_d;
    logic [3:0]           dm_q, dm_d;
    logic                 sat_flag_q, sat_flag_d;
    logic                 ovf_flag_q, ovf_flag_d;

    logic                 warm_done, accept, keep, clip;
    logic signed [RW-1:0] in_ext, rnd_sum;
    logic [3:0]           dm_load, dm_eff;
    logic [OUT_WIDTH-1:0] sat_val;
    logic                 fifo_drop;

    assign warm_done = (warm_cnt_q == WCW'(WARMUP));
    assign accept    = in_valid && warm_done && !flush;

    // Extra MSB keeps the rounding add from overflowing.
    assign in_ext  = {in_data[IN_WIDTH-1], in_data};
    assign rnd_sum = in_ext + $signed(ROUND_K);

    // The factor is latched only when a phase-0 sample is consumed, so a
    // decim_m change never splits a decimation frame.
    assign dm_load = (decim_m == 4'd0) ? 4'd1 : decim_m;
    assign dm_eff  = (phase_q == 4'd0) ? dm_load : dm_q;
    assign keep    = s1_valid_q && (phase_q == 4'd0) && !flush;

    always_comb begin
        clip    = 1'b0;
        sat_val = s1_r_q[OUT_WIDTH-1:0];
        if (s1_r_q > SAT_MAX) begin
            clip    = 1'b1;
            sat_val = SAT_MAX[OUT_WIDTH-1:0];
        end else if (s1_r_q < SAT_MIN) begin
            clip    = 1'b1;
            sat_val = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        warm_cnt_d = warm_cnt_q;
        s1_valid_d = accept;
        s1_r_d     = s1_r_q;
        phase_d    = phase_q;
        dm_d       = dm_q;
        if (flush) begin
            warm_cnt_d = '0;
            phase_d    = 4'd0;
        end else begin
            if (in_valid && !warm_done) begin
                warm_cnt_d = warm_cnt_q + WCW'(1);
            end
            if (accept) begin
                s1_r_d = rnd_sum >>> SHIFT;
            end
            if (s1_valid_q) begin
                if (phase_q == 4'd0) begin
                    dm_d = dm_load;
                end
                phase_d = (phase_q >= dm_eff - 4'd1) ? 4'd0 : phase_q + 4'd1;
            end
        end

        // Set beats clear when both happen in the same cycle.
        sat_flag_d = clr_flags ? 1'b0 : sat_flag_q;
        ovf_flag_d = clr_flags ? 1'b0 : ovf_flag_q;
        if (keep && clip) begin
            sat_flag_d = 1'b1;
        end
        if (fifo_drop) begin
            ovf_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_q <= '0;
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            phase_q    <= 4'd0;
            dm_q       <= 4'd1;
            sat_flag_q <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            phase_q    <= phase_d;
            dm_q       <= dm_d;
            sat_flag_q <= sat_flag_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (keep),
        .push_dat  (sat_val),
        .pop       (out_ready),
        .pop_vld   (out_valid),
        .pop_dat   (out_data),
        .push_drop (fifo_drop),
        .level     (fifo_level)
    );

    assign sat_flag = sat_flag_q;
    assign ovf_flag = ovf_flag_q;

endmodule

// File: tb/tb_fir_output_requant.sv
// Directed bench for fir_output_requant: warm-up, latency, rounding, saturation,
// decimation, backpressure/overflow, flush and asynchronous reset.
module tb_fir_output_requant;

    localparam int IW = 35;
    localparam int OW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic signed [IW-1:0] in_data;
    logic [3:0]           decim_m;
    logic                 flush;
    logic                 clr_flags;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 sat_flag;
    logic                 ovf_flag;
    logic [2:0]           fifo_level;

    int checks   = 0;
    int failures = 0;
    int max_level = 0;
    logic signed [OW-1:0] got [$];

    always #5 clk = ~clk;

    fir_output_requant dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .decim_m    (decim_m),
        .flush      (flush),
        .clr_flags  (clr_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sat_flag   (sat_flag),
        .ovf_flag   (ovf_flag),
        .fifo_level (fifo_level)
    );

    // Record every accepted head mid-cycle, i.e. the word the next edge pops.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [IW-1:0] q15(input int v);
        logic signed [IW-1:0] t;
        t = IW'(v);
        return t <<< 15;
    endfunction

    function automatic logic signed [OW-1:0] got_at(input int i);
        logic signed [OW-1:0] g;
        g = 'x;
        if (i < got.size()) g = got[i];
        return g;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; decim_m = 4'd1;
        flush = 1'b0; clr_flags = 1'b0; out_ready = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (sat_flag !== 1'b0 || ovf_flag !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", sat_flag, ovf_flag); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_warmup();
        decim_m = 4'd1; out_ready = 1'b1; got.delete(); max_level = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; in_data = q15(k); tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        checks++; if (got.size() != 8) begin failures++; $display("FAIL warmup_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_at(i) !== OW'(12 + i)) begin failures++; $display("FAIL warmup_value[%0d] got=%0d exp=%0d", i, got_at(i), 12 + i); end
        end
        checks++; if (max_level > 2) begin failures++; $display("FAIL warmup_max_level got=%0d exp<=2", max_level); end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = q15(7); tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'sd7) begin failures++; $display("FAIL latency_out got=%b/%0d exp=1/7", out_valid, out_data); end
        tick();
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL latency_drain got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_rounding();
        int                   vals [4] = '{49152, -49152, 16383, 3276800};
        logic signed [OW-1:0] exps [4] = '{16'sd2, -16'sd1, 16'sd0, 16'sd100};
        got.delete(); out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = IW'(vals[i]); tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        checks++; if (got.size() != 4) begin failures++; $display("FAIL round_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_at(i) !== exps[i]) begin failures++; $display("FAIL round[%0d] got=%0d exp=%0d", i, got_at(i), exps[i]); end
        end
        checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL round_sat_flag got=%b exp=0", sat_flag); end
    endtask

    task automatic test_saturation();
        got.delete(); out_ready = 1'b1;
        in_valid = 1'b1; in_data = q15(65536); tick();
        in_data = q15(-524288); tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++; if (got_at(0) !== 16'sd32767) begin failures++; $display("FAIL sat_pos got=%0d exp=32767", got_at(0)); end
        checks++; if (got_at(1) !== -16'sd32768) begin failures++; $display("FAIL sat_neg got=%0d exp=-32768", got_at(1)); end
        checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_flag_set got=%b exp=1", sat_flag); end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat_flag_clr got=%b exp=0", sat_flag); end
        // Clipping sample reaches stage 2 in the same cycle as clr_flags.
        in_valid = 1'b1; in_data = q15(65536); tick();
        in_valid = 1'b0; clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_set_wins got=%b exp=1", sat_flag); end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat_flag_clr2 got=%b exp=0", sat_flag); end
        repeat (2) tick();
    endtask

    task automatic test_decimation();
        logic signed [OW-1:0] exps [7] = '{16'sd0, 16'sd3, 16'sd6, 16'sd9, 16'sd12, 16'sd14, 16'sd16};
        got.delete(); out_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            decim_m  = (i < 11) ? 4'd3 : ((i < 16) ? 4'd2 : 4'd1);
            in_valid = 1'b1; in_data = q15(i); tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        checks++; if (got.size() != 7) begin failures++; $display("FAIL decim_count got=%0d exp=7", got.size()); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (got_at(i) !== exps[i]) begin failures++; $display("FAIL decim[%0d] got=%0d exp=%0d", i, got_at(i), exps[i]); end
        end
    endtask

    task automatic test_overflow();
        logic signed [OW-1:0] exps [5] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd7};
        got.delete(); out_ready = 1'b0; decim_m = 4'd1;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_data = q15(i); tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
        checks++; if (ovf_flag !== 1'b1) begin failures++; $display("FAIL ovf_flag_set got=%b exp=1", ovf_flag); end
        checks++; if (out_valid !== 1'b1 || out_data !== 16'sd1) begin failures++; $display("FAIL ovf_head_hold got=%b/%0d exp=1/1", out_valid, out_data); end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        checks++; if (ovf_flag !== 1'b0) begin failures++; $display("FAIL ovf_flag_clr got=%b exp=0", ovf_flag); end
        in_valid = 1'b1; in_data = q15(7); tick();
        in_valid = 1'b0; out_ready = 1'b1; tick();
        out_ready = 1'b0;
        checks++; if (fifo_level !== 3'd4 || ovf_flag !== 1'b0) begin failures++; $display("FAIL full_rw got=%0d/%b exp=4/0", fifo_level, ovf_flag); end
        out_ready = 1'b1;
        repeat (6) tick();
        checks++; if (got.size() != 5) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_at(i) !== exps[i]) begin failures++; $display("FAIL ovf_order[%0d] got=%0d exp=%0d", i, got_at(i), exps[i]); end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 21; i <= 23; i++) begin
            in_valid = 1'b1; in_data = q15(i); tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL flush_pre_level got=%0d exp=3", fifo_level); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0d/%b exp=0/0", fifo_level, out_valid); end
        got.delete(); out_ready = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            in_valid = 1'b1; in_data = q15(100 + i); tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        checks++; if (got.size() != 1) begin failures++; $display("FAIL flush_warmup_count got=%0d exp=1", got.size()); end
        checks++; if (got_at(0) !== 16'sd112) begin failures++; $display("FAIL flush_first got=%0d exp=112", got_at(0)); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = q15(65536); tick();
        in_data = q15(5); tick();
        in_valid = 1'b0;
        repeat (3) tick();
        checks++; if (fifo_level !== 3'd2 || sat_flag !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%0d/%b exp=2/1", fifo_level, sat_flag); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'sd0) begin failures++; $display("FAIL midrst_out got=%b/%0d exp=0/0", out_valid, out_data); end
        checks++; if (fifo_level !== 3'd0 || sat_flag !== 1'b0 || ovf_flag !== 1'b0) begin failures++; $display("FAIL midrst_state got=%0d/%b%b exp=0/00", fifo_level, sat_flag, ovf_flag); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_latency();
        test_rounding();
        test_saturation();
        test_decimation();
        test_overflow();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
